trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 32 +++
 rtl/trap_ctrl_target_calc.sv | 79 +++++++
 rtl/trap_ctrl.sv | 149 ++++++++++++++
 tb/tb_trap_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the trap controller: FSM states, request kinds,
// privilege levels, mstatus bit positions and the illegal-instruction cause.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTER    = 2'd1,
    ST_RETURN   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_TRAP = 2'd0,
    KIND_MRET = 2'd1,
    KIND_SRET = 2'd2
  } kind_e;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] ILLEGAL_INST = 32'd2;

endpackage

// File: rtl/trap_ctrl_target_calc.sv
// Combinational trap/return resolution: delegation decision, new mstatus
// bits {MPP,MPIE,MIE,SPP,SPIE,SIE}, next privilege and the redirect target.
module trap_target_calc
  import trap_ctrl_pkg::*;
(
  input  kind_e       kind_i,
  input  logic [31:0] cause_i,
  input  logic [1:0]  privilege_i,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] medeleg_i,
  input  logic [31:0] mideleg_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] stvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] sepc_i,
  output logic        to_s_o,
  output logic [6:0]  status_set_o,
  output logic [1:0]  priv_set_o,
  output logic [31:0] target_pc_o
);

  logic        is_irq;
  logic        deleg_bit;
  logic [1:0]  mpp;
  logic        mpie, mie, spp, spie, sie;
  logic [31:0] tvec;
  logic [31:0] base;
  logic        unused_bits;

  assign unused_bits = ^{mstatus_i[63:13], mstatus_i[10:9], mstatus_i[6], mstatus_i[4],
                         mstatus_i[2], mstatus_i[0], cause_i[30:6]};

  assign mpp  = mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
  assign mpie = mstatus_i[MSTATUS_MPIE];
  assign mie  = mstatus_i[MSTATUS_MIE];
  assign spp  = mstatus_i[MSTATUS_SPP];
  assign spie = mstatus_i[MSTATUS_SPIE];
  assign sie  = mstatus_i[MSTATUS_SIE];

  assign is_irq    = cause_i[31];
  assign deleg_bit = is_irq ? mideleg_i[cause_i[4:0]] : medeleg_i[cause_i[5:0]];
  assign to_s_o    = (kind_i == KIND_TRAP) && (privilege_i != PRIV_M) && deleg_bit;

  always_comb begin
    status_set_o = {mpp, mpie, mie, spp, spie, sie};
    priv_set_o   = PRIV_M;
    target_pc_o  = '0;
    tvec         = to_s_o ? stvec_i : mtvec_i;
    base         = {tvec[31:2], 2'b00};
    case (kind_i)
      KIND_TRAP: begin
        // Only mode 01 with an interrupt vectors; every other mode uses the base.
        if (tvec[1:0] == 2'b01 && is_irq)
          target_pc_o = base + {25'd0, cause_i[4:0], 2'b00};
        else
          target_pc_o = base;
        if (to_s_o) begin
          status_set_o = {mpp, mpie, mie, privilege_i[0], sie, 1'b0};
          priv_set_o   = PRIV_S;
        end else begin
          status_set_o = {privilege_i, mie, 1'b0, spp, spie, sie};
          priv_set_o   = PRIV_M;
        end
      end
      KIND_MRET: begin
        status_set_o = {PRIV_U, 1'b1, mpie, spp, spie, sie};
        priv_set_o   = mpp;
        target_pc_o  = mepc_i;
      end
      KIND_SRET: begin
        status_set_o = {mpp, mpie, mie, 1'b0, 1'b1, spie};
        priv_set_o   = {1'b0, spp};
        target_pc_o  = sepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / xRET sequencer: accepts one request in IDLE, issues a single
// cycle of CSR and privilege updates, then a one-cycle pipeline redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        trapReq_i,
  input  logic [31:0] trapCause_i,
  input  logic [31:0] trapPc_i,
  input  logic        mretReq_i,
  input  logic        sretReq_i,
  input  logic [31:0] retPc_i,
  output logic        reqReady_o,
  input  logic [63:0] csrMStatus_i,
  input  logic [63:0] csrMedeleg_i,
  input  logic [31:0] csrMideleg_i,
  input  logic [31:0] csrMtvec_i,
  input  logic [31:0] csrStvec_i,
  input  logic [31:0] csrMepc_i,
  input  logic [31:0] csrSepc_i,
  input  logic [31:0] csrMCause_i,
  input  logic [31:0] csrSCause_i,
  input  logic [1:0]  privilege_i,
  output logic [6:0]  csrMStatusSet_o,
  output logic [31:0] csrMepcSet_o,
  output logic [31:0] csrMCauseSet_o,
  output logic [31:0] csrSepcSet_o,
  output logic [31:0] csrSCauseSet_o,
  output logic        csrTrapSetEn_o,
  output logic [1:0]  privilegeSet_o,
  output logic        privilegeSetEn_o,
  output logic        redirectValid_o,
  output logic [31:0] redirectPc_o,
  output logic        flush_o,
  output logic        busy_o
);

  state_e      state_q;
  kind_e       kind_q;
  logic [31:0] cause_q;
  logic [31:1] pc_q;
  logic        redir_vld_q;
  logic [31:0] redir_pc_q;

  logic        to_s;
  logic [6:0]  status_set;
  logic [1:0]  priv_set;
  logic [31:0] target_pc;

  trap_target_calc u_calc (
    .kind_i       (kind_q),
    .cause_i      (cause_q),
    .privilege_i  (privilege_i),
    .mstatus_i    (csrMStatus_i),
    .medeleg_i    (csrMedeleg_i),
    .mideleg_i    (csrMideleg_i),
    .mtvec_i      (csrMtvec_i),
    .stvec_i      (csrStvec_i),
    .mepc_i       (csrMepc_i),
    .sepc_i       (csrSepc_i),
    .to_s_o       (to_s),
    .status_set_o (status_set),
    .priv_set_o   (priv_set),
    .target_pc_o  (target_pc)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_TRAP;
      cause_q     <= '0;
      pc_q        <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (trapReq_i) begin
            state_q <= ST_ENTER;
            kind_q  <= KIND_TRAP;
            cause_q <= trapCause_i;
            pc_q    <= trapPc_i[31:1];
          end else if ((mretReq_i && privilege_i != PRIV_M) ||
                       (!mretReq_i && sretReq_i && privilege_i == PRIV_U)) begin
            // xRET from an insufficient privilege becomes an illegal-instruction trap.
            state_q <= ST_ENTER;
            kind_q  <= KIND_TRAP;
            cause_q <= ILLEGAL_INST;
            pc_q    <= retPc_i[31:1];
          end else if (mretReq_i || sretReq_i) begin
            state_q <= ST_RETURN;
            kind_q  <= mretReq_i ? KIND_MRET : KIND_SRET;
            cause_q <= '0;
            pc_q    <= retPc_i[31:1];
          end
        end
        ST_ENTER, ST_RETURN: begin
          state_q     <= ST_REDIRECT;
          redir_vld_q <= 1'b1;
          redir_pc_q  <= target_pc;
        end
        ST_REDIRECT: state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign reqReady_o      = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign redirectValid_o = redir_vld_q;
  assign redirectPc_o    = redir_pc_q;

  // Untargeted epc/cause outputs echo the CSR inputs so the joint write is a no-op.
  always_comb begin
    csrTrapSetEn_o   = 1'b0;
    privilegeSetEn_o = 1'b0;
    flush_o          = 1'b0;
    csrMStatusSet_o  = '0;
    privilegeSet_o   = '0;
    csrMepcSet_o     = '0;
    csrMCauseSet_o   = '0;
    csrSepcSet_o     = '0;
    csrSCauseSet_o   = '0;
    if (state_q == ST_ENTER || state_q == ST_RETURN) begin
      csrTrapSetEn_o   = 1'b1;
      privilegeSetEn_o = 1'b1;
      flush_o          = 1'b1;
      csrMStatusSet_o  = status_set;
      privilegeSet_o   = priv_set;
      csrMepcSet_o     = csrMepc_i;
      csrMCauseSet_o   = csrMCause_i;
      csrSepcSet_o     = csrSepc_i;
      csrSCauseSet_o   = csrSCause_i;
      if (state_q == ST_ENTER) begin
        if (to_s) begin
          csrSepcSet_o   = {pc_q, 1'b0};
          csrSCauseSet_o = cause_q;
        end else begin
          csrMepcSet_o   = {pc_q, 1'b0};
          csrMCauseSet_o = cause_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, delegation, vectoring, xRET,
// illegal xRET, request priority/holding and asynchronous reset.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        trapReq_i, mretReq_i, sretReq_i;
  logic [31:0] trapCause_i, trapPc_i, retPc_i;
  logic        reqReady_o;
  logic [63:0] csrMStatus_i, csrMedeleg_i;
  logic [31:0] csrMideleg_i, csrMtvec_i, csrStvec_i, csrMepc_i, csrSepc_i, csrMCause_i, csrSCause_i;
  logic [1:0]  privilege_i;
  logic [6:0]  csrMStatusSet_o;
  logic [31:0] csrMepcSet_o, csrMCauseSet_o, csrSepcSet_o, csrSCauseSet_o;
  logic        csrTrapSetEn_o;
  logic [1:0]  privilegeSet_o;
  logic        privilegeSetEn_o, redirectValid_o, flush_o, busy_o;
  logic [31:0] redirectPc_o;

  int checks = 0;
  int errors = 0;

  logic [174:0] all_outs;
  logic [5:0]   ctl;
  logic [8:0]   stat;
  logic [127:0] epc;
  logic [35:0]  redir;

  assign all_outs = {reqReady_o, busy_o, redirectValid_o, redirectPc_o, flush_o, csrTrapSetEn_o,
                     privilegeSetEn_o, privilegeSet_o, csrMStatusSet_o, csrMepcSet_o,
                     csrMCauseSet_o, csrSepcSet_o, csrSCauseSet_o};
  assign ctl   = {csrTrapSetEn_o, privilegeSetEn_o, flush_o, busy_o, reqReady_o, redirectValid_o};
  assign stat  = {csrMStatusSet_o, privilegeSet_o};
  assign epc   = {csrMepcSet_o, csrMCauseSet_o, csrSepcSet_o, csrSCauseSet_o};
  assign redir = {redirectValid_o, redirectPc_o, csrTrapSetEn_o, privilegeSetEn_o, flush_o};

  trap_ctrl dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .trapReq_i(trapReq_i), .trapCause_i(trapCause_i), .trapPc_i(trapPc_i),
    .mretReq_i(mretReq_i), .sretReq_i(sretReq_i), .retPc_i(retPc_i), .reqReady_o(reqReady_o),
    .csrMStatus_i(csrMStatus_i), .csrMedeleg_i(csrMedeleg_i), .csrMideleg_i(csrMideleg_i),
    .csrMtvec_i(csrMtvec_i), .csrStvec_i(csrStvec_i), .csrMepc_i(csrMepc_i), .csrSepc_i(csrSepc_i),
    .csrMCause_i(csrMCause_i), .csrSCause_i(csrSCause_i), .privilege_i(privilege_i),
    .csrMStatusSet_o(csrMStatusSet_o), .csrMepcSet_o(csrMepcSet_o), .csrMCauseSet_o(csrMCauseSet_o),
    .csrSepcSet_o(csrSepcSet_o), .csrSCauseSet_o(csrSCauseSet_o), .csrTrapSetEn_o(csrTrapSetEn_o),
    .privilegeSet_o(privilegeSet_o), .privilegeSetEn_o(privilegeSetEn_o),
    .redirectValid_o(redirectValid_o), .redirectPc_o(redirectPc_o), .flush_o(flush_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_csr(input logic [1:0] priv, input logic [63:0] mstatus, input logic [63:0] medeleg,
                         input logic [31:0] mideleg, input logic [31:0] mtvec, input logic [31:0] stvec);
    privilege_i  = priv;
    csrMStatus_i = mstatus;
    csrMedeleg_i = medeleg;
    csrMideleg_i = mideleg;
    csrMtvec_i   = mtvec;
    csrStvec_i   = stvec;
    csrMepc_i    = 32'h0000_AAA0;
    csrSepc_i    = 32'h0000_5550;
    csrMCause_i  = 32'h66;
    csrSCause_i  = 32'h77;
  endtask

  // Present a request at a falling edge; returns 2 ns into the ENTER/RETURN cycle.
  task automatic issue(input logic t, input logic m, input logic s,
                       input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] rpc);
    @(negedge clk_i);
    trapReq_i = t; mretReq_i = m; sretReq_i = s;
    trapCause_i = cause; trapPc_i = pc; retPc_i = rpc;
    @(posedge clk_i);
    #1;
    trapReq_i = 1'b0; mretReq_i = 1'b0; sretReq_i = 1'b0;
    #1;
  endtask

  task automatic next_cycle;
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (all_outs !== {1'b1, 174'd0}) begin errors++; $display("FAIL reset_outs got %h exp %h", all_outs, {1'b1, 174'd0}); end
    @(negedge clk_i); reset_n_i = 1'b1;
    #1;
    checks++; if (all_outs !== {1'b1, 174'd0}) begin errors++; $display("FAIL idle_outs got %h exp %h", all_outs, {1'b1, 174'd0}); end
  endtask

  task automatic test_m_ecall;
    set_csr(2'd3, 64'h8, 64'h800, 32'h0, 32'h8000_0000, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 32'd11, 32'h100, 32'h0);
    checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL ecall_ctl got %b exp %b", ctl, 6'b111100); end
    checks++; if (stat !== {7'h70, 2'd3}) begin errors++; $display("FAIL ecall_status got %h exp %h", stat, {7'h70, 2'd3}); end
    checks++; if (epc !== {32'h100, 32'd11, 32'h5550, 32'h77}) begin errors++; $display("FAIL ecall_epc got %h exp %h", epc, {32'h100, 32'd11, 32'h5550, 32'h77}); end
    next_cycle;
    checks++; if (redir !== {1'b1, 32'h8000_0000, 3'b000}) begin errors++; $display("FAIL ecall_redirect got %h exp %h", redir, {1'b1, 32'h8000_0000, 3'b000}); end
    next_cycle;
    checks++; if ({reqReady_o, busy_o, redirectValid_o} !== 3'b100) begin errors++; $display("FAIL ecall_idle got %b exp %b", {reqReady_o, busy_o, redirectValid_o}, 3'b100); end
  endtask

  task automatic test_delegated_fault;
    set_csr(2'd0, 64'h2, 64'h2000, 32'h0, 32'h8000_0000, 32'h4000);
    issue(1'b1, 1'b0, 1'b0, 32'd13, 32'h1235, 32'h0);
    checks++; if (stat !== {7'h02, 2'd1}) begin errors++; $display("FAIL deleg_status got %h exp %h", stat, {7'h02, 2'd1}); end
    checks++; if (epc !== {32'hAAA0, 32'h66, 32'h1234, 32'd13}) begin errors++; $display("FAIL deleg_epc got %h exp %h", epc, {32'hAAA0, 32'h66, 32'h1234, 32'd13}); end
    next_cycle;
    checks++; if (redir !== {1'b1, 32'h4000, 3'b000}) begin errors++; $display("FAIL deleg_redirect got %h exp %h", redir, {1'b1, 32'h4000, 3'b000}); end
    next_cycle;
  endtask

  task automatic test_vectored;
    set_csr(2'd3, 64'h0, 64'h0, 32'hFFFF_FFFF, 32'h2001, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 32'h8000_0007, 32'h700, 32'h0);
    checks++; if (stat !== {7'h60, 2'd3}) begin errors++; $display("FAIL virq_status got %h exp %h", stat, {7'h60, 2'd3}); end
    checks++; if (epc !== {32'h700, 32'h8000_0007, 32'h5550, 32'h77}) begin errors++; $display("FAIL virq_epc got %h exp %h", epc, {32'h700, 32'h8000_0007, 32'h5550, 32'h77}); end
    next_cycle;
    checks++; if (redir !== {1'b1, 32'h201C, 3'b000}) begin errors++; $display("FAIL virq_redirect got %h exp %h", redir, {1'b1, 32'h201C, 3'b000}); end
    next_cycle;
    issue(1'b1, 1'b0, 1'b0, 32'd5, 32'h704, 32'h0);
    next_cycle;
    checks++; if (redirectPc_o !== 32'h2000) begin errors++; $display("FAIL vexc_redirect got %h exp %h", redirectPc_o, 32'h2000); end
    next_cycle;
    set_csr(2'd1, 64'h0, 64'h0, 32'h20, 32'h2001, 32'h4001);
    issue(1'b1, 1'b0, 1'b0, 32'h8000_0005, 32'h800, 32'h0);
    checks++; if (stat !== {7'h04, 2'd1}) begin errors++; $display("FAIL sirq_status got %h exp %h", stat, {7'h04, 2'd1}); end
    checks++; if (epc !== {32'hAAA0, 32'h66, 32'h800, 32'h8000_0005}) begin errors++; $display("FAIL sirq_epc got %h exp %h", epc, {32'hAAA0, 32'h66, 32'h800, 32'h8000_0005}); end
    next_cycle;
    checks++; if (redirectPc_o !== 32'h4014) begin errors++; $display("FAIL sirq_redirect got %h exp %h", redirectPc_o, 32'h4014); end
    next_cycle;
  endtask

  task automatic test_xret;
    set_csr(2'd3, 64'h80, 64'h0, 32'h0, 32'h8000_0000, 32'h0);
    csrMepc_i = 32'h300;
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h2000);
    checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL mret_ctl got %b exp %b", ctl, 6'b111100); end
    checks++; if (stat !== {7'h18, 2'd0}) begin errors++; $display("FAIL mret_status got %h exp %h", stat, {7'h18, 2'd0}); end
    checks++; if (epc !== {32'h300, 32'h66, 32'h5550, 32'h77}) begin errors++; $display("FAIL mret_epc got %h exp %h", epc, {32'h300, 32'h66, 32'h5550, 32'h77}); end
    next_cycle;
    checks++; if (redir !== {1'b1, 32'h300, 3'b000}) begin errors++; $display("FAIL mret_redirect got %h exp %h", redir, {1'b1, 32'h300, 3'b000}); end
    next_cycle;
    privilege_i = 2'd0;
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h444);
    checks++; if (stat !== {7'h00, 2'd3}) begin errors++; $display("FAIL illmret_status got %h exp %h", stat, {7'h00, 2'd3}); end
    checks++; if (epc !== {32'h444, 32'd2, 32'h5550, 32'h77}) begin errors++; $display("FAIL illmret_epc got %h exp %h", epc, {32'h444, 32'd2, 32'h5550, 32'h77}); end
    next_cycle;
    checks++; if (redirectPc_o !== 32'h8000_0000) begin errors++; $display("FAIL illmret_redirect got %h exp %h", redirectPc_o, 32'h8000_0000); end
    next_cycle;
    set_csr(2'd1, 64'h120, 64'h0, 32'h0, 32'h8000_0000, 32'h0);
    csrSepc_i = 32'h500;
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h3000);
    checks++; if (stat !== {7'h03, 2'd1}) begin errors++; $display("FAIL sret_status got %h exp %h", stat, {7'h03, 2'd1}); end
    next_cycle;
    checks++; if (redirectPc_o !== 32'h500) begin errors++; $display("FAIL sret_redirect got %h exp %h", redirectPc_o, 32'h500); end
    next_cycle;
  endtask

  task automatic test_back_to_back;
    set_csr(2'd3, 64'h0, 64'h0, 32'h0, 32'h8000_0000, 32'h0);
    @(negedge clk_i);
    trapReq_i = 1'b1; mretReq_i = 1'b1; trapCause_i = 32'd8; trapPc_i = 32'h10; retPc_i = 32'h20;
    @(posedge clk_i);
    #1;
    mretReq_i = 1'b0; trapCause_i = 32'd3; trapPc_i = 32'h600;
    #1;
    checks++; if ({ctl, csrMepcSet_o, csrMCauseSet_o} !== {6'b111100, 32'h10, 32'd8}) begin errors++; $display("FAIL b2b_first got %h exp %h", {ctl, csrMepcSet_o, csrMCauseSet_o}, {6'b111100, 32'h10, 32'd8}); end
    next_cycle;
    checks++; if ({redirectValid_o, reqReady_o, csrTrapSetEn_o} !== 3'b100) begin errors++; $display("FAIL b2b_hold got %b exp %b", {redirectValid_o, reqReady_o, csrTrapSetEn_o}, 3'b100); end
    next_cycle;
    checks++; if ({reqReady_o, redirectValid_o} !== 2'b10) begin errors++; $display("FAIL b2b_ready got %b exp %b", {reqReady_o, redirectValid_o}, 2'b10); end
    @(posedge clk_i);
    #1;
    trapReq_i = 1'b0;
    #1;
    checks++; if ({csrTrapSetEn_o, csrMepcSet_o, csrMCauseSet_o} !== {1'b1, 32'h600, 32'd3}) begin errors++; $display("FAIL b2b_second got %h exp %h", {csrTrapSetEn_o, csrMepcSet_o, csrMCauseSet_o}, {1'b1, 32'h600, 32'd3}); end
    next_cycle;
    next_cycle;
  endtask

  task automatic test_reset_mid;
    set_csr(2'd3, 64'h8, 64'h0, 32'h0, 32'h8000_0000, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 32'd11, 32'h100, 32'h0);
    reset_n_i = 1'b0;
    #1;
    checks++; if (all_outs !== {1'b1, 174'd0}) begin errors++; $display("FAIL rstmid_outs got %h exp %h", all_outs, {1'b1, 174'd0}); end
    @(posedge clk_i);
    #1;
    checks++; if (all_outs !== {1'b1, 174'd0}) begin errors++; $display("FAIL rstmid_noredir got %h exp %h", all_outs, {1'b1, 174'd0}); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    trapReq_i = 1'b1; trapCause_i = 32'd11; trapPc_i = 32'h20;
    @(posedge clk_i);
    #1;
    trapReq_i = 1'b0;
    #1;
    checks++; if ({csrTrapSetEn_o, csrMepcSet_o} !== {1'b1, 32'h20}) begin errors++; $display("FAIL rst_first_accept got %h exp %h", {csrTrapSetEn_o, csrMepcSet_o}, {1'b1, 32'h20}); end
    next_cycle;
    checks++; if (redir !== {1'b1, 32'h8000_0000, 3'b000}) begin errors++; $display("FAIL rst_redirect got %h exp %h", redir, {1'b1, 32'h8000_0000, 3'b000}); end
    next_cycle;
  endtask

  initial begin
    reset_n_i = 1'b0;
    trapReq_i = 1'b0; mretReq_i = 1'b0; sretReq_i = 1'b0;
    trapCause_i = '0; trapPc_i = '0; retPc_i = '0;
    set_csr(2'd3, 64'h0, 64'h0, 32'h0, 32'h0, 32'h0);
    test_reset;
    test_m_ecall;
    test_delegated_fault;
    test_vectored;
    test_xret;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
